// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op-code map, op width and FSM encoding.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_MOV = 4'd6;
  localparam logic [OP_W-1:0] OP_INC = 4'd7;
  localparam logic [OP_W-1:0] OP_DEC = 4'd8;
  localparam logic [OP_W-1:0] OP_SHL = 4'd9;
  localparam logic [OP_W-1:0] OP_SHR = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL = 4'd11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_if.sv
// Command/result bundle between the register-file read ports and the ALU stage.
interface alu_if #(parameter int N = 8);
  import alu_pkg::*;

  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic [OP_W-1:0] op;
  logic            start;
  logic            busy;
  logic            done;
  logic [N-1:0]    y;
  logic            z;
  logic            n;
  logic            o;

  modport master (output a, b, op, start, input busy, done, y, z, n, o);
  modport slave  (input a, b, op, start, output busy, done, y, z, n, o);
endinterface

// File: rtl/mul_seq.sv
// N-step shift-add unsigned multiplier; product is the accumulator plus the current
// partial term, so it is final in the cycle where last is high.
module mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           last,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = busy && (cnt == CW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Registered execute stage: single-cycle ALU ops plus a sequenced multiply.
//   state  | meaning
//   S_IDLE | accepts start; single-cycle ops retire at the accepting edge
//   S_MUL  | multiplier stepping; start ignored until the product is written
module alu_stage
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  state_t         state;
  logic [N-1:0]   y_q;
  logic           z_q, n_q, o_q, done_q;
  logic [N-1:0]   alu_y;
  logic           alu_o, alu_ok;
  logic           mul_load, mul_busy, mul_last;
  logic [2*N-1:0] mul_p;

  assign mul_load = (state == S_IDLE) && bus.start && (bus.op == OP_MUL);

  mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_p)
  );

  always_comb begin
    alu_y  = '0;
    alu_o  = 1'b0;
    alu_ok = 1'b1;
    case (bus.op)
      OP_ADD: begin
        alu_y = bus.a + bus.b;
        alu_o = (bus.a[N-1] == bus.b[N-1]) && (alu_y[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        alu_y = bus.a - bus.b;
        alu_o = (bus.a[N-1] != bus.b[N-1]) && (alu_y[N-1] != bus.a[N-1]);
      end
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_NOT: alu_y = ~bus.a;
      OP_MOV: alu_y = bus.a;
      OP_INC: begin
        alu_y = bus.a + N'(1);
        alu_o = !bus.a[N-1] && alu_y[N-1];
      end
      OP_DEC: begin
        alu_y = bus.a - N'(1);
        alu_o = bus.a[N-1] && !alu_y[N-1];
      end
      OP_SHL: alu_y = bus.a << 1;
      OP_SHR: alu_y = bus.a >> 1;
      default: alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      y_q    <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      o_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              state <= S_MUL;
            end else begin
              // reserved ops still acknowledge but leave the result untouched
              done_q <= 1'b1;
              if (alu_ok) begin
                y_q <= alu_y;
                z_q <= (alu_y == '0);
                n_q <= alu_y[N-1];
                o_q <= alu_o;
              end
            end
          end
        end
        S_MUL: begin
          if (mul_busy && mul_last) begin
            y_q    <= mul_p[N-1:0];
            z_q    <= (mul_p[N-1:0] == '0);
            n_q    <= mul_p[N-1];
            o_q    <= |mul_p[2*N-1:N];
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == S_MUL);
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.z    = z_q;
  assign bus.n    = n_q;
  assign bus.o    = o_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: vector table for single-cycle ops, hand sequences for multiply.
module tb_alu_stage;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
    logic       n;
    logic       o;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];

  alu_if #(.N(8)) bus ();

  alu_stage #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic chk_res(input string name, input logic [7:0] y, input logic z,
                         input logic n, input logic o);
    chk({name, ".y"}, 32'(bus.y), 32'(y));
    chk({name, ".z"}, 32'(bus.z), 32'(z));
    chk({name, ".n"}, 32'(bus.n), 32'(n));
    chk({name, ".o"}, 32'(bus.o), 32'(o));
  endtask

  // Runs while busy, counting busy cycles and done pulses; optionally fires an ADD mid-multiply.
  task automatic mul_wait(input bit inject, output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (bus.busy && cycles < 20) begin
      cycles++;
      if (bus.done) dones++;
      if (inject && cycles == 3) begin
        bus.op    = OP_ADD;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, dn;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_DEC, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{OP_SHR, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{OP_MOV, 8'h00, 8'h12, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{OP_INC, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{OP_INC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{OP_DEC, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = '0;
    bus.start = 1'b0;
    repeat (3) step();
    chk_res("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    rst = 1'b0;
    step();
    chk_res("idle", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("idle.done", 32'(bus.done), 0);

    // back-to-back single-cycle ops, one per clock
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk_res($sformatf("vec%0d", i), vecs[i].y, vecs[i].z, vecs[i].n, vecs[i].o);
      chk($sformatf("vec%0d.done", i), 32'(bus.done), 1);
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 0);
    end
    step();
    chk("single.done_low", 32'(bus.done), 0);
    chk("single.hold_y", 32'(bus.y), 32'h00FF);

    // MUL 12 x 13 = 156
    issue(OP_MUL, 8'd12, 8'd13);
    chk("mul1.done_at_accept", 32'(bus.done), 0);
    mul_wait(1'b0, cyc, dn);
    chk("mul1.busy_cycles", 32'(cyc), 8);
    chk("mul1.early_done", 32'(dn), 0);
    chk("mul1.done", 32'(bus.done), 1);
    chk_res("mul1", 8'h9C, 1'b0, 1'b1, 1'b0);
    step();
    chk("mul1.done_low", 32'(bus.done), 0);

    // MUL 16 x 16 = 0x100
    issue(OP_MUL, 8'd16, 8'd16);
    mul_wait(1'b0, cyc, dn);
    chk("mul2.busy_cycles", 32'(cyc), 8);
    chk("mul2.done", 32'(bus.done), 1);
    chk_res("mul2", 8'h00, 1'b1, 1'b0, 1'b1);

    // ADD strobed mid-multiply is dropped; 15 x 17 = 255
    issue(OP_MUL, 8'd15, 8'd17);
    mul_wait(1'b1, cyc, dn);
    chk("mul3.busy_cycles", 32'(cyc), 8);
    chk("mul3.early_done", 32'(dn), 0);
    chk("mul3.done", 32'(bus.done), 1);
    chk_res("mul3", 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    chk("mul3.no_extra_done", 32'(bus.done), 0);
    chk("mul3.hold_y", 32'(bus.y), 32'h00FF);

    // ADD issued in the done cycle of a multiply
    issue(OP_MUL, 8'd2, 8'd3);
    mul_wait(1'b0, cyc, dn);
    chk("mul4.done", 32'(bus.done), 1);
    chk("mul4.y", 32'(bus.y), 32'h0006);
    issue(OP_ADD, 8'd3, 8'd4);
    chk("add_in_done.done", 32'(bus.done), 1);
    chk_res("add_in_done", 8'h07, 1'b0, 1'b0, 1'b0);

    // reserved op acknowledges without touching the result
    issue(4'd14, 8'h55, 8'hAA);
    chk("reserved.done", 32'(bus.done), 1);
    chk("reserved.busy", 32'(bus.busy), 0);
    chk_res("reserved", 8'h07, 1'b0, 1'b0, 1'b0);
    step();
    chk("reserved.done_low", 32'(bus.done), 0);

    // reset during multiply step 4 discards the partial product
    issue(OP_SUB, 8'h00, 8'h01);
    chk_res("pre_rst", 8'hFF, 1'b0, 1'b1, 1'b0);
    issue(OP_MUL, 8'd12, 8'd13);
    repeat (3) step();
    chk("pre_rst.busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst.busy", 32'(bus.busy), 0);
    chk("mid_rst.done", 32'(bus.done), 0);
    chk_res("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.busy) dn++;
    end
    chk("post_rst.quiet", 32'(dn), 0);
    chk("post_rst.y", 32'(bus.y), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
